text_area_write_ctrl: RTL and testbench
=======================================

Name: text_area_write_ctrl

Overview:
- Owns port B of the text-area memory, which holds one 16-bit word per cell: {color[15:8], ascii[7:0]}. Port A is the read-only display fetch path.
- Accepts a character stream (terminal-style: printable, CR, LF, BS), tracks the cursor, and writes cells.
- Sequences two bulk operations on the same port: full-screen clear, and one-line scroll-up (read/copy/blank).
- Sits between the character source (UART/keyboard decoder) and the text-area memory; the display path is untouched.

Parameters:
- COLS, 80, characters per row (address = row*COLS + col).
- ROWS, 60, rows on screen.
- ADDR_W, 13, memory address width; COLS*ROWS <= 2**ADDR_W.
- BLANK_COLOR, 8'h07, color byte written with space (0x20) by clear, scroll-blank and BS.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- char_valid  in  1  source has a character.
- char_data  in  8  ASCII code.
- char_color  in  8  color byte for a printable character.
- char_ready  out  1  character accepted when char_valid && char_ready at a rising edge.
- clear_req  in  1  request full-screen clear (sampled in IDLE only).
- busy  out  1  high whenever state != IDLE.
- mem_we  out  1  port B write enable.
- mem_addr  out  ADDR_W  port B address.
- mem_din  out  16  port B write data.
- mem_dout  in  16  port B read data; valid one cycle after the address is presented.
- cursor_col  out  7  current column.
- cursor_row  out  7  current row.

Behaviour:
- Reset (asynchronous, active-low):
  - State IDLE; cursor (0,0); cursor address register 0.
  - mem_we=0, mem_addr=0, mem_din=0, busy=0.
- Cursor address is kept incrementally (+1 per column, +COLS per row). No multiplier.
- States: IDLE, PUT, CLEAR, SC_RD, SC_LAT, SC_WR, SC_BLANK.
- IDLE:
  - char_ready = !clear_req.
  - mem_we=0; mem_addr = cursor address.
  - clear_req has priority over char_valid in the same cycle: go to CLEAR, character not accepted.
- Accepted character, decoded in IDLE:
  - 0x20..0x7E: go to PUT with data {char_color, char_data}; advance flag set.
  - 0x0D (CR): col <- 0; stay IDLE; no write.
  - 0x0A (LF): col <- 0. If row < ROWS-1, row++ and stay IDLE. Otherwise go to SC_RD.
  - 0x08 (BS): if col > 0, col <- col-1 and go to PUT with {BLANK_COLOR, 0x20}, advance flag clear. If col == 0, no-op.
  - Any other code: accepted and dropped.
- PUT (exactly 1 cycle):
  - mem_we=1, mem_addr = cursor address, mem_din = latched word.
  - At the end of the cycle, if advance is set: col++. If col was COLS-1, col <- 0 and row++. If row was ROWS-1, go to SC_RD with row held at ROWS-1.
  - Otherwise return to IDLE.
  - Printable character throughput is therefore 1 per 2 cycles.
- CLEAR:
  - One write per cycle: mem_we=1, addr 0..COLS*ROWS-1 ascending, din {BLANK_COLOR, 0x20}.
  - After the last address: cursor (0,0), back to IDLE.
  - busy lasts exactly COLS*ROWS cycles.
- Scroll:
  - Destination index d runs 0..(ROWS-1)*COLS-1.
  - SC_RD: mem_we=0, mem_addr = d+COLS.
  - SC_LAT: capture mem_dout into a hold register.
  - SC_WR: mem_we=1, mem_addr = d, mem_din = hold; d++.
  - After the last d, go to SC_BLANK: write {BLANK_COLOR, 0x20} to (ROWS-1)*COLS .. ROWS*COLS-1, one per cycle.
  - Then cursor (0, ROWS-1), back to IDLE.
  - busy lasts exactly 3*(ROWS-1)*COLS + COLS cycles (14240 at the defaults).
- While busy:
  - char_ready=0.
  - clear_req is ignored and not queued; the source must hold it until busy falls.
- Outputs:
  - mem_we, mem_addr, mem_din are functions of state registers only. There is no combinational path from mem_dout or the char inputs to them.
  - mem_we is never high in IDLE, SC_RD or SC_LAT.
- Reset asserted mid-operation: immediate abort as in the reset clause. Partially written memory is left as is; no completion is attempted.

Test Plan:
1. Reset; send 'A' (0x41), color 0x1F -> next cycle mem_we=1, mem_addr=0, mem_din=16'h1F41. Cursor then (col 1, row 0); char_ready low for exactly 1 cycle.
2. Send 80 printables from (0,0) -> writes to addr 0..79, cursor ends at (col 0, row 1). Then CR, then LF -> cursor (0,2) with no mem_we pulses.
3. Cursor at (col 5, row 2), send 0x08 -> one write to addr 164 with din 16'h0720, cursor col 4. Cursor at col 0, send 0x08 -> no write, cursor unchanged.
4. Assert clear_req together with char_valid in IDLE -> char_ready=0; 4800 consecutive writes to addr 0..4799 with din 16'h0720; busy high exactly 4800 cycles; cursor (0,0).
5. Preload cell k with k[15:0]; cursor at row 59; send LF -> addr 0..4719 receive old contents of 80..4799, addr 4720..4799 become 16'h0720. busy = 14240 cycles; cursor (0,59); no write in any SC_RD/SC_LAT cycle.
6. Cursor (79,59), send 'Z' -> write at addr 4799, then a full scroll, cursor (0,59). Pull rst_n low mid-scroll -> mem_we=0 and busy=0 without waiting for a clock edge; cursor (0,0).

Source files
------------

// File: rtl/text_area_write_if.sv
// ============================================================================
// Module      : text_area_write_if
// Description : Character stream, status and text-area port B bundle.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface text_area_write_if #(
    parameter int ADDR_W = 13
) ();
    logic              char_valid;
    logic [7:0]        char_data;
    logic [7:0]        char_color;
    logic              char_ready;
    logic              clear_req;
    logic              busy;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_din;
    logic [15:0]       mem_dout;
    logic [6:0]        cursor_col;
    logic [6:0]        cursor_row;

    // Source / memory side: feeds characters and returns read data.
    modport master (
        output char_valid, char_data, char_color, clear_req, mem_dout,
        input  char_ready, busy, mem_we, mem_addr, mem_din, cursor_col, cursor_row
    );

    // Controller side.
    modport slave (
        input  char_valid, char_data, char_color, clear_req, mem_dout,
        output char_ready, busy, mem_we, mem_addr, mem_din, cursor_col, cursor_row
    );
endinterface

`default_nettype wire

// File: rtl/text_area_write_ctrl.sv
// ============================================================================
// Module      : text_area_write_ctrl
// Description : Terminal-style writer for text-area port B: cursor tracking,
//               character writes, full-screen clear and one-line scroll-up.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module text_area_write_ctrl #(
    parameter int         COLS        = 80,
    parameter int         ROWS        = 60,
    parameter int         ADDR_W      = 13,
    parameter logic [7:0] BLANK_COLOR = 8'h07
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    text_area_write_if.slave bus
);

    localparam logic [ADDR_W-1:0] COLS_A        = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] ONE_A         = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] LAST_CELL     = ADDR_W'(COLS * ROWS - 1);
    localparam logic [ADDR_W-1:0] LAST_DST      = ADDR_W'((ROWS - 1) * COLS - 1);
    localparam logic [ADDR_W-1:0] LAST_ROW_BASE = ADDR_W'((ROWS - 1) * COLS);
    localparam logic [6:0]        LAST_COL      = 7'(COLS - 1);
    localparam logic [6:0]        LAST_ROW      = 7'(ROWS - 1);
    localparam logic [15:0]       BLANK_WORD    = {BLANK_COLOR, 8'h20};

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PUT      = 3'd1,
        CLEAR    = 3'd2,
        SC_RD    = 3'd3,
        SC_LAT   = 3'd4,
        SC_WR    = 3'd5,
        SC_BLANK = 3'd6
    } state_t;

    state_t            state, state_n;
    logic [6:0]        col, col_n;
    logic [6:0]        row, row_n;
    logic [ADDR_W-1:0] caddr, caddr_n;
    logic [ADDR_W-1:0] idx, idx_n;
    logic [15:0]       word, word_n;
    logic              adv, adv_n;
    logic [15:0]       hold, hold_n;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_din;
    logic              char_ready;
    logic [7:0]        ch;

    assign ch = bus.char_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            col   <= '0;
            row   <= '0;
            caddr <= '0;
            idx   <= '0;
            word  <= '0;
            adv   <= 1'b0;
            hold  <= '0;
        end else begin
            state <= state_n;
            col   <= col_n;
            row   <= row_n;
            caddr <= caddr_n;
            idx   <= idx_n;
            word  <= word_n;
            adv   <= adv_n;
            hold  <= hold_n;
        end
    end

    always_comb begin
        state_n = state;
        col_n   = col;
        row_n   = row;
        caddr_n = caddr;
        idx_n   = idx;
        word_n  = word;
        adv_n   = adv;
        hold_n  = hold;
        case (state)
            IDLE: begin
                if (bus.clear_req) begin
                    state_n = CLEAR;
                    idx_n   = '0;
                end else if (bus.char_valid) begin
                    if (ch >= 8'h20 && ch <= 8'h7E) begin
                        state_n = PUT;
                        word_n  = {bus.char_color, ch};
                        adv_n   = 1'b1;
                    end else begin
                        case (ch)
                            8'h0D: begin
                                col_n   = '0;
                                caddr_n = caddr - ADDR_W'(col);
                            end
                            8'h0A: begin
                                col_n = '0;
                                if (row < LAST_ROW) begin
                                    row_n   = row + 7'd1;
                                    caddr_n = caddr - ADDR_W'(col) + COLS_A;
                                end else begin
                                    state_n = SC_RD;
                                    idx_n   = '0;
                                end
                            end
                            8'h08: begin
                                if (col != 7'd0) begin
                                    col_n   = col - 7'd1;
                                    caddr_n = caddr - ONE_A;
                                    word_n  = BLANK_WORD;
                                    adv_n   = 1'b0;
                                    state_n = PUT;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            end
            PUT: begin
                state_n = IDLE;
                if (adv) begin
                    // Wrapping from the last column lands exactly on the next row base.
                    if (col == LAST_COL) begin
                        col_n = '0;
                        if (row == LAST_ROW) begin
                            state_n = SC_RD;
                            idx_n   = '0;
                        end else begin
                            row_n   = row + 7'd1;
                            caddr_n = caddr + ONE_A;
                        end
                    end else begin
                        col_n   = col + 7'd1;
                        caddr_n = caddr + ONE_A;
                    end
                end
            end
            CLEAR: begin
                if (idx == LAST_CELL) begin
                    state_n = IDLE;
                    col_n   = '0;
                    row_n   = '0;
                    caddr_n = '0;
                end else begin
                    idx_n = idx + ONE_A;
                end
            end
            SC_RD:  state_n = SC_LAT;
            SC_LAT: begin
                hold_n  = bus.mem_dout;
                state_n = SC_WR;
            end
            SC_WR: begin
                // idx continues straight into the last-row blanking range.
                idx_n   = idx + ONE_A;
                state_n = (idx == LAST_DST) ? SC_BLANK : SC_RD;
            end
            SC_BLANK: begin
                if (idx == LAST_CELL) begin
                    state_n = IDLE;
                    col_n   = '0;
                    row_n   = LAST_ROW;
                    caddr_n = LAST_ROW_BASE;
                end else begin
                    idx_n = idx + ONE_A;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Port B drive depends only on registered state.
    always_comb begin
        mem_we     = 1'b0;
        mem_addr   = caddr;
        mem_din    = '0;
        char_ready = 1'b0;
        case (state)
            IDLE:  char_ready = !bus.clear_req;
            PUT: begin
                mem_we  = 1'b1;
                mem_din = word;
            end
            CLEAR: begin
                mem_we   = 1'b1;
                mem_addr = idx;
                mem_din  = BLANK_WORD;
            end
            SC_RD, SC_LAT: mem_addr = idx + COLS_A;
            SC_WR: begin
                mem_we   = 1'b1;
                mem_addr = idx;
                mem_din  = hold;
            end
            SC_BLANK: begin
                mem_we   = 1'b1;
                mem_addr = idx;
                mem_din  = BLANK_WORD;
            end
            default: ;
        endcase
    end

    assign bus.mem_we     = mem_we;
    assign bus.mem_addr   = mem_addr;
    assign bus.mem_din    = mem_din;
    assign bus.char_ready = char_ready;
    assign bus.busy       = (state != IDLE);
    assign bus.cursor_col = col;
    assign bus.cursor_row = row;

    a_no_read_write: assert property (@(posedge clk) disable iff (!rst_n)
        (state == IDLE || state == SC_RD || state == SC_LAT) |-> !mem_we);
    a_cursor_range: assert property (@(posedge clk) disable iff (!rst_n)
        (col <= LAST_COL) && (row <= LAST_ROW));

endmodule

`default_nettype wire

// File: tb/tb_text_area_write_ctrl.sv
// ============================================================================
// Module      : tb_text_area_write_ctrl
// Description : Scoreboard bench for text_area_write_ctrl with a screen model.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_text_area_write_ctrl;
    localparam int COLS   = 80;
    localparam int ROWS   = 60;
    localparam int ADDR_W = 13;
    localparam int CELLS  = COLS * ROWS;
    localparam logic [15:0] BLANK = 16'h0720;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    text_area_write_if #(.ADDR_W(ADDR_W)) bus ();

    text_area_write_ctrl #(
        .COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W), .BLANK_COLOR(8'h07)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Port B memory: synchronous write, one-cycle registered read.
    logic [15:0] mem [0:(1<<ADDR_W)-1];
    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_din;
        bus.mem_dout <= mem[bus.mem_addr];
    end

    // Reference model: a screen of cells plus a cursor.
    logic [15:0] scr [0:CELLS-1];
    int m_col, m_row;
    logic [28:0] exp_q [$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_wr(input int a, input logic [15:0] d);
        exp_q.push_back({13'(a), d});
        scr[a] = d;
    endtask

    task automatic model_scroll();
        for (int d = 0; d < (ROWS - 1) * COLS; d++) push_wr(d, scr[d + COLS]);
        for (int a = (ROWS - 1) * COLS; a < CELLS; a++) push_wr(a, BLANK);
        m_col = 0;
        m_row = ROWS - 1;
    endtask

    task automatic model_char(input logic [7:0] c, input logic [7:0] colr);
        if (c >= 8'h20 && c <= 8'h7E) begin
            push_wr(m_row * COLS + m_col, {colr, c});
            m_col++;
            if (m_col == COLS) begin
                m_col = 0;
                if (m_row == ROWS - 1) model_scroll();
                else m_row++;
            end
        end else if (c == 8'h0D) begin
            m_col = 0;
        end else if (c == 8'h0A) begin
            m_col = 0;
            if (m_row < ROWS - 1) m_row++;
            else model_scroll();
        end else if (c == 8'h08 && m_col > 0) begin
            m_col--;
            push_wr(m_row * COLS + m_col, BLANK);
        end
    endtask

    // Monitor: every observed write must match the oldest expected write.
    always @(negedge clk) begin
        if (rst_n && bus.mem_we) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL mem_write: unexpected write addr %0d din %0h at %0t",
                         bus.mem_addr, bus.mem_din, $time);
            end else begin
                check("mem_write", {3'b0, bus.mem_addr, bus.mem_din}, {3'b0, exp_q.pop_front()});
            end
        end
    end

    task automatic send_char(input logic [7:0] c, input logic [7:0] colr);
        bit ok = 1'b0;
        for (int i = 0; i < 20000 && !ok; i++) begin
            @(negedge clk);
            bus.char_valid = 1'b1;
            bus.char_data  = c;
            bus.char_color = colr;
            #1;
            if (bus.char_ready) begin
                @(posedge clk);
                ok = 1'b1;
                model_char(c, colr);
            end
        end
        #1 bus.char_valid = 1'b0;
        check("char_accept", {31'b0, ok}, 32'd1);
    endtask

    task automatic wait_idle();
        bit idle = 1'b0;
        for (int i = 0; i < 20000 && !idle; i++) begin
            @(negedge clk);
            idle = !bus.busy;
        end
        check("idle_reached", {31'b0, idle}, 32'd1);
    endtask

    task automatic check_cursor(input string name);
        check(name, {18'b0, bus.cursor_row, bus.cursor_col},
              {18'b0, 7'(m_row), 7'(m_col)});
    endtask

    task automatic measure_busy(output int n);
        n = 0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (!bus.busy) break;
            n++;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.char_valid = 1'b0;
        bus.clear_req  = 1'b0;
        exp_q.delete();
        m_col = 0;
        m_row = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        logic [7:0] c;
        int r;
        bus.char_valid = 1'b0;
        bus.char_data  = 8'h0;
        bus.char_color = 8'h0;
        bus.clear_req  = 1'b0;
        for (int k = 0; k < (1 << ADDR_W); k++) mem[k] = 16'h0;
        for (int k = 0; k < CELLS; k++) scr[k] = 16'h0;

        // Reset state and first printable character.
        do_reset();
        #1;
        check("rst_mem_we",   {31'b0, bus.mem_we}, 32'd0);
        check("rst_mem_addr", {19'b0, bus.mem_addr}, 32'd0);
        check("rst_mem_din",  {16'b0, bus.mem_din}, 32'd0);
        check("rst_busy",     {31'b0, bus.busy}, 32'd0);
        check("rst_ready",    {31'b0, bus.char_ready}, 32'd1);
        check_cursor("rst_cursor");
        send_char(8'h41, 8'h1F);
        @(negedge clk);
        check("put_ready_low", {31'b0, bus.char_ready}, 32'd0);
        @(negedge clk);
        check("put_ready_back", {31'b0, bus.char_ready}, 32'd1);
        check_cursor("cursor_after_A");

        // A full row of printables wraps to the next row; CR/LF write nothing.
        do_reset();
        for (int i = 0; i < COLS; i++) begin
            send_char(8'(8'h30 + (i % 40)), 8'h2A);
        end
        wait_idle();
        check_cursor("cursor_row_wrap");
        send_char(8'h0D, 8'h00);
        send_char(8'h0A, 8'h00);
        wait_idle();
        check_cursor("cursor_cr_lf");

        // Backspace in mid-row and at column 0.
        for (int i = 0; i < 5; i++) send_char(8'h61, 8'h33);
        send_char(8'h08, 8'h55);
        wait_idle();
        check_cursor("cursor_bs");
        send_char(8'h0D, 8'h00);
        send_char(8'h08, 8'h55);
        wait_idle();
        check_cursor("cursor_bs_col0");

        // Clear has priority over a simultaneous character.
        @(negedge clk);
        bus.clear_req  = 1'b1;
        bus.char_valid = 1'b1;
        bus.char_data  = 8'h42;
        #1;
        check("clear_ready_low", {31'b0, bus.char_ready}, 32'd0);
        @(posedge clk);
        for (int a = 0; a < CELLS; a++) push_wr(a, BLANK);
        m_col = 0;
        m_row = 0;
        #1;
        bus.clear_req  = 1'b0;
        bus.char_valid = 1'b0;
        measure_busy(n);
        check("clear_busy_cycles", 32'(n), 32'(CELLS));
        check_cursor("cursor_after_clear");

        // Randomized terminal traffic.
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if (r < 70)      c = 8'($urandom_range(32, 126));
            else if (r < 78) c = 8'h0D;
            else if (r < 84) c = 8'h0A;
            else if (r < 93) c = 8'h08;
            else if (r < 96) c = 8'($urandom_range(14, 31));
            else             c = 8'($urandom_range(127, 255));
            send_char(c, 8'($urandom));
            wait_idle();
            check_cursor("cursor_random");
        end

        // Scroll from the bottom row over a preloaded screen.
        do_reset();
        for (int k = 0; k < CELLS; k++) begin
            mem[k] = 16'(k);
            scr[k] = 16'(k);
        end
        for (int i = 0; i < ROWS - 1; i++) send_char(8'h0A, 8'h00);
        wait_idle();
        check_cursor("cursor_last_row");
        send_char(8'h0A, 8'h00);
        measure_busy(n);
        check("scroll_busy_cycles", 32'(n), 32'(3 * (ROWS - 1) * COLS + COLS));
        check_cursor("cursor_after_scroll");
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        // Printable at the last cell triggers a scroll; reset aborts it.
        for (int i = 0; i < COLS - 1; i++) send_char(8'h2E, 8'h1E);
        wait_idle();
        check_cursor("cursor_79_59");
        send_char(8'h5A, 8'h4F);
        repeat (1000) @(negedge clk);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        m_col = 0;
        m_row = 0;
        #1;
        check("abort_mem_we", {31'b0, bus.mem_we}, 32'd0);
        check("abort_busy",   {31'b0, bus.busy}, 32'd0);
        check_cursor("abort_cursor");
        @(negedge clk);
        rst_n = 1'b1;
        send_char(8'h51, 8'h12);
        wait_idle();
        check_cursor("cursor_post_abort");
        check("final_queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
